// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store.
// Round-robin arbitration, one access in flight, fixed memory latency.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            r_state, w_state;
    logic [2:0]        r_cnt, w_cnt;
    logic              r_last_ls, w_last_ls;
    logic              r_win_ls, w_win_ls;
    logic              r_store, w_store;
    logic              r_mem_en, w_mem_en;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_if_gnt, w_if_gnt;
    logic              r_ls_gnt, w_ls_gnt;
    logic              r_if_rvalid, w_if_rvalid;
    logic              r_ls_rvalid, w_ls_rvalid;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata, w_ls_rdata;
    logic              w_pick_ls;

    // LS wins if alone, or if both ask and IF was served last.
    assign w_pick_ls = i_ls_req && (!i_if_req || !r_last_ls);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_last_ls   = r_last_ls;
        w_win_ls    = r_win_ls;
        w_store     = r_store;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_if_gnt    = 1'b0;
        w_ls_gnt    = 1'b0;
        w_if_rvalid = 1'b0;
        w_ls_rvalid = 1'b0;
        w_if_rdata  = r_if_rdata;
        w_ls_rdata  = r_ls_rdata;
        unique case (r_state)
            StIdle: begin
                if (i_if_req || i_ls_req) begin
                    w_state  = StAccess;
                    w_cnt    = 3'(MEM_LAT);
                    w_win_ls = w_pick_ls;
                    w_mem_en = 1'b1;
                    if (w_pick_ls) begin
                        w_ls_gnt   = 1'b1;
                        w_store    = i_ls_we;
                        w_mem_we   = i_ls_we;
                        w_mem_addr = i_ls_addr;
                        if (i_ls_we) begin
                            w_mem_wdata = i_ls_wdata;
                        end
                    end else begin
                        w_if_gnt   = 1'b1;
                        w_store    = 1'b0;
                        w_mem_addr = i_if_addr;
                    end
                end
            end
            StAccess: begin
                // The strobe cycle does not count: data lands MEM_LAT cycles after it.
                if (r_mem_en) begin
                    w_cnt = r_cnt;
                end else if (r_cnt == 3'd1) begin
                    w_state = StResp;
                    w_cnt   = 3'd0;
                    if (r_win_ls) begin
                        w_ls_rvalid = 1'b1;
                        if (!r_store) begin
                            w_ls_rdata = i_mem_rdata;
                        end
                    end else begin
                        w_if_rvalid = 1'b1;
                        w_if_rdata  = i_mem_rdata;
                    end
                end else begin
                    w_cnt = r_cnt - 3'd1;
                end
            end
            StResp: begin
                w_state   = StIdle;
                w_last_ls = r_win_ls;
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_last_ls   <= 1'b1;
            r_win_ls    <= 1'b0;
            r_store     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_last_ls   <= w_last_ls;
            r_win_ls    <= w_win_ls;
            r_store     <= w_store;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_if_gnt    <= w_if_gnt;
            r_ls_gnt    <= w_ls_gnt;
            r_if_rvalid <= w_if_rvalid;
            r_ls_rvalid <= w_ls_rvalid;
            r_if_rdata  <= w_if_rdata;
            r_ls_rdata  <= w_ls_rdata;
        end
    end

    assign o_if_gnt    = r_if_gnt;
    assign o_ls_gnt    = r_ls_gnt;
    assign o_if_rvalid = r_if_rvalid;
    assign o_ls_rvalid = r_ls_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_ls_rdata  = r_ls_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != StIdle);

endmodule
